filter_decide: RTL and testbench
================================

FILTER_DECIDE -- requirements
Module: filter_decide

Interface
REQ-001 Parameter C_S_AXIS_DATA_WIDTH, default 256, tap data width; only 256 is supported.
REQ-002 Parameter C_S_AXIS_TUSER_WIDTH, default 128, tap tuser width; tuser is not interpreted.
REQ-003 axi_aclk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tap_tdata  in  256  observed stream data; packet byte i at bits [8i+7:8i].
REQ-006 tap_tstrb  in  32  observed byte strobes.
REQ-007 tap_tvalid / tap_tready / tap_tlast  in  1 each  observed handshake; a beat is accepted when tap_tvalid&tap_tready.
REQ-008 tap_stall  out  1  request to upstream to hold tap_tready low; the top level ANDs it in.
REQ-009 filter_en  in  1  enable for drop rule; quasi-static.
REQ-010 filter_src_addr  in  32  IPv4 source address to drop.
REQ-011 result_wr_en  out  1  write strobe into the downstream verdict FIFO.
REQ-012 result_din  out  1  verdict: 1 = forward packet, 0 = drop.
REQ-013 result_nearly_full  in  1  backpressure from the verdict FIFO.
REQ-014 pass_count, drop_count  out  32 each  verdicts written, wrapping counters.
REQ-015 overflow  out  1  sticky error flag.

Function
REQ-016 The block shall be passive on data: it never drives tdata/tvalid; it only issues exactly one verdict per accepted packet, in packet order.
REQ-017 Packet FSM, 2 states: HEAD (next beat is first of packet) and BODY; HEAD->BODY on an accepted beat with tlast=0; BODY->HEAD on an accepted beat with tlast=1; single-beat packet (first beat tlast=1) stays in HEAD.
REQ-018 On the accepted first beat, the verdict shall be computed: ethertype = {byte12,byte13}; ip_src = {byte26,byte27,byte28,byte29}.
REQ-019 Drop (verdict 0) iff filter_en=1 AND tap_tstrb[29:0] all ones AND ethertype=16'h0800 AND ip_src=filter_src_addr; otherwise verdict 1.
REQ-020 Runt first beat (any of tap_tstrb[29:0] = 0) shall yield verdict 1.
REQ-021 The verdict shall be latched into a one-entry holding register with a pending flag set on the cycle after the first beat.
REQ-022 result_wr_en shall be asserted combinationally when pending=1 and result_nearly_full=0; result_din shall equal the held verdict; pending clears on that cycle.
REQ-023 Minimum latency: first beat accepted at cycle N -> result_wr_en high at cycle N+1.
REQ-024 tap_stall shall equal pending OR result_nearly_full, registered-free (combinational from state).
REQ-025 If a first beat is accepted while pending=1 and not being written in the same cycle, the new verdict shall be discarded, the held verdict kept, and overflow set until reset.
REQ-026 If pending is written and a new first beat is accepted in the same cycle, the new verdict shall load and pending stays 1; no overflow.
REQ-027 pass_count increments on each result_wr_en with result_din=1; drop_count on result_din=0; both wrap 2^32-1 -> 0.
REQ-028 Non-first beats (BODY) shall not affect the verdict; filter_en/filter_src_addr are sampled only on the first beat.
REQ-029 tap_tuser and body-beat tstrb shall be ignored.

Reset
REQ-030 While reset=1 on a clock edge: FSM = HEAD, pending = 0, held verdict = 1, overflow = 0, counters = 0.
REQ-031 During and after reset result_wr_en = 0 and tap_stall = result_nearly_full; a packet in flight at reset is forgotten and the next accepted beat is a first beat.

Verification
REQ-032 Single 3-beat IPv4 packet, ip_src=10.0.0.5, filter_src_addr=32'h0A000005, filter_en=1 -> result_wr_en one cycle after beat 1, result_din=0, drop_count=1.
REQ-033 Same packet with filter_en=0, then ethertype 16'h86DD with matching bytes -> two verdicts of 1, pass_count=2.
REQ-034 result_nearly_full held high 10 cycles after first beat -> tap_stall high, no result_wr_en until release, then exactly one write; overflow=0.
REQ-035 Force a first beat while pending with nearly_full=1 -> overflow=1, only the first verdict written, counters total 1.
REQ-036 Back-to-back single-beat packets every cycle, nearly_full=0 -> one verdict per cycle, in order, no overflow.
REQ-037 Reset asserted mid-packet (BODY) -> next accepted beat parsed as first beat; counters 0; runt 20-byte first beat -> verdict 1.

Source files
------------

// File: rtl/filter_decide.sv
// Purpose : per-packet forward/drop verdict for an observed AXI-Stream tap (IPv4 source-address drop rule).
// Latency : verdict offered on result_wr_en the cycle after the accepted first beat.
// Backpres: one-entry verdict holder; tap_stall = pending | result_nearly_full; a first beat arriving when the holder cannot drain sets sticky overflow.
module filter_decide #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axi_aclk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    tap_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  tap_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   tap_tuser,
    input  logic                              tap_tvalid,
    input  logic                              tap_tready,
    input  logic                              tap_tlast,
    output logic                              tap_stall,
    input  logic                              filter_en,
    input  logic [31:0]                       filter_src_addr,
    output logic                              result_wr_en,
    output logic                              result_din,
    input  logic                              result_nearly_full,
    output logic [31:0]                       pass_count,
    output logic [31:0]                       drop_count,
    output logic                              overflow
);

    typedef enum logic {HEAD = 1'b0, BODY = 1'b1} pkt_state_e;

    pkt_state_e  state_q, state_d;
    logic        pending_q, pending_d;
    logic        verdict_q, verdict_d;
    logic        overflow_q, overflow_d;
    logic [31:0] pass_q, drop_q;

    logic        beat_acc;
    logic        first_acc;
    logic [15:0] ethertype;
    logic [31:0] ip_src;
    logic        new_verdict;

    // Header fields sit at fixed byte offsets of the first beat (byte i at bits [8i+7:8i]).
    assign ethertype = {tap_tdata[12*8 +: 8], tap_tdata[13*8 +: 8]};
    assign ip_src    = {tap_tdata[26*8 +: 8], tap_tdata[27*8 +: 8],
                        tap_tdata[28*8 +: 8], tap_tdata[29*8 +: 8]};

    assign beat_acc  = tap_tvalid & tap_tready;
    assign first_acc = beat_acc & (state_q == HEAD);

    // Drop only a complete IPv4 header whose source matches; a runt first beat always forwards.
    assign new_verdict = ~(filter_en & (&tap_tstrb[29:0]) &
                           (ethertype == 16'h0800) & (ip_src == filter_src_addr));

    // Holder drains whenever the FIFO has room; gated by reset so nothing is written while resetting.
    assign result_wr_en = pending_q & ~result_nearly_full & ~reset;
    assign result_din   = verdict_q;
    assign tap_stall    = (pending_q & ~reset) | result_nearly_full;

    assign pass_count = pass_q;
    assign drop_count = drop_q;
    assign overflow   = overflow_q;

    // Next-state: packet framing FSM plus verdict holder / overflow bookkeeping.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        verdict_d  = verdict_q;
        overflow_d = overflow_q;

        case (state_q)
            HEAD:    if (beat_acc && !tap_tlast) state_d = BODY;
            BODY:    if (beat_acc &&  tap_tlast) state_d = HEAD;
            default: state_d = HEAD;
        endcase

        if (result_wr_en) begin
            pending_d = 1'b0;
        end

        if (first_acc) begin
            if (pending_q && !result_wr_en) begin
                // Holder still occupied: keep the older verdict, lose the new one.
                overflow_d = 1'b1;
            end else begin
                verdict_d = new_verdict;
                pending_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_q    <= HEAD;
            pending_q  <= 1'b0;
            verdict_q  <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            verdict_q  <= verdict_d;
            overflow_q <= overflow_d;
        end
    end

    // Verdict counters, free-running with natural 32-bit wrap.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            pass_q <= 32'd0;
            drop_q <= 32'd0;
        end else if (result_wr_en) begin
            if (result_din) pass_q <= pass_q + 32'd1;
            else            drop_q <= drop_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_filter_decide.sv
module tb_filter_decide;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] tap_tdata;
    logic [31:0]  tap_tstrb;
    logic [127:0] tap_tuser;
    logic         tap_tvalid, tap_tready, tap_tlast;
    logic         tap_stall;
    logic         filter_en;
    logic [31:0]  filter_src_addr;
    logic         result_wr_en, result_din, result_nearly_full;
    logic [31:0]  pass_count, drop_count;
    logic         overflow;

    int errors = 0;
    int checks = 0;
    logic exp_q[$];

    filter_decide dut (
        .axi_aclk           (clk),
        .reset              (reset),
        .tap_tdata          (tap_tdata),
        .tap_tstrb          (tap_tstrb),
        .tap_tuser          (tap_tuser),
        .tap_tvalid         (tap_tvalid),
        .tap_tready         (tap_tready),
        .tap_tlast          (tap_tlast),
        .tap_stall          (tap_stall),
        .filter_en          (filter_en),
        .filter_src_addr    (filter_src_addr),
        .result_wr_en       (result_wr_en),
        .result_din         (result_din),
        .result_nearly_full (result_nearly_full),
        .pass_count         (pass_count),
        .drop_count         (drop_count),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build a beat with given ethertype and IPv4 source; other bytes are random filler.
    function automatic logic [255:0] mk(input logic [15:0] et, input logic [31:0] src);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        d[12*8 +: 8] = et[15:8];
        d[13*8 +: 8] = et[7:0];
        d[26*8 +: 8] = src[31:24];
        d[27*8 +: 8] = src[23:16];
        d[28*8 +: 8] = src[15:8];
        d[29*8 +: 8] = src[7:0];
        return d;
    endfunction

    // One accepted beat; optionally record the verdict the scoreboard should see.
    task automatic beat(input logic [255:0] d, input logic [31:0] s, input logic last,
                        input logic push, input logic exp);
        tap_tdata  = d;
        tap_tstrb  = s;
        tap_tlast  = last;
        tap_tuser  = {4{$urandom}};
        tap_tvalid = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        tap_tvalid = 1'b0;
        tap_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every verdict write is matched against the head of the queue.
    always @(negedge clk) begin
        if (!reset && result_wr_en) begin
            check("sb_expected_write", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_verdict", 32'(result_din), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] SRC  = 32'h0A000005;
    localparam logic [31:0] FULL = 32'hFFFFFFFF;

    initial begin
        int bad;
        logic [255:0] hit, miss;
        reset = 1'b1; result_nearly_full = 1'b0;
        tap_tvalid = 1'b0; tap_tready = 1'b1; tap_tlast = 1'b0;
        tap_tdata = '0; tap_tstrb = '0; tap_tuser = '0;
        filter_en = 1'b0; filter_src_addr = 32'h0;
        idle(2);
        check("rst_wr_en", 32'(result_wr_en), 32'd0);
        check("rst_stall_nf0", 32'(tap_stall), 32'd0);
        result_nearly_full = 1'b1; #1;
        check("rst_stall_nf1", 32'(tap_stall), 32'd1);
        result_nearly_full = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(1);
        check("rst_pass", pass_count, 32'd0);
        check("rst_drop", drop_count, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // 3-beat IPv4 packet matching the filter -> drop, one cycle after beat 1
        filter_en = 1'b1; filter_src_addr = SRC;
        hit = mk(16'h0800, SRC);
        beat(hit, FULL, 1'b0, 1'b1, 1'b0);
        check("lat_wr_en", 32'(result_wr_en), 32'd1);
        check("lat_din", 32'(result_din), 32'd0);
        beat(mk(16'h0000, 32'h0), FULL, 1'b0, 1'b0, 1'b0);
        beat(mk(16'h0000, 32'h0), 32'h0000000F, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("drop_cnt_1", drop_count, 32'd1);
        check("pass_cnt_0", pass_count, 32'd0);

        // filter disabled, then IPv6 ethertype with matching bytes; body carries a matching header
        filter_en = 1'b0;
        beat(mk(16'h0800, SRC), FULL, 1'b0, 1'b1, 1'b1);
        filter_en = 1'b1;
        beat(mk(16'h0800, SRC), FULL, 1'b0, 1'b0, 1'b0);
        beat(mk(16'h0800, SRC), FULL, 1'b1, 1'b0, 1'b0);
        beat(mk(16'h86DD, SRC), FULL, 1'b0, 1'b1, 1'b1);
        beat(hit, FULL, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("pass_cnt_2", pass_count, 32'd2);
        check("drop_cnt_still_1", drop_count, 32'd1);

        // nearly_full holds the verdict for 10 cycles, then exactly one write
        result_nearly_full = 1'b1;
        beat(hit, FULL, 1'b1, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (tap_stall !== 1'b1 || result_wr_en !== 1'b0) bad++;
            idle(1);
        end
        check("nf_hold_cycles", bad, 0);
        result_nearly_full = 1'b0; #1;
        check("nf_release_wr", 32'(result_wr_en), 32'd1);
        idle(1);
        check("nf_single_wr", 32'(result_wr_en), 32'd0);
        check("nf_drop_cnt", drop_count, 32'd2);
        check("nf_ovf", 32'(overflow), 32'd0);

        // back-to-back single-beat packets, one verdict per cycle in order
        miss = mk(16'h0800, 32'h0A000006);
        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 0) beat(hit, FULL, 1'b1, 1'b1, 1'b0);
            else            beat(miss, FULL, 1'b1, 1'b1, 1'b1);
        end
        bad = 0;
        if (result_wr_en !== 1'b1) bad++;
        idle(1);
        check("b2b_last_write_next_cycle", bad, 0);
        idle(1);
        check("b2b_drop_cnt", drop_count, 32'd5);
        check("b2b_pass_cnt", pass_count, 32'd7);
        check("b2b_ovf", 32'(overflow), 32'd0);

        // first beat while pending and blocked -> overflow, second verdict discarded
        result_nearly_full = 1'b1;
        beat(miss, FULL, 1'b1, 1'b1, 1'b1);
        beat(hit, FULL, 1'b1, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        result_nearly_full = 1'b0;
        idle(4);
        check("ovf_pass_cnt", pass_count, 32'd8);
        check("ovf_drop_cnt", drop_count, 32'd5);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // reset mid-packet: pending verdict and BODY state forgotten
        result_nearly_full = 1'b1;
        beat(hit, FULL, 1'b0, 1'b0, 1'b0);
        beat(miss, FULL, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        idle(2);
        check("mid_rst_wr_en", 32'(result_wr_en), 32'd0);
        check("mid_rst_stall", 32'(tap_stall), 32'd1);
        result_nearly_full = 1'b0; #1;
        check("mid_rst_stall_nf0", 32'(tap_stall), 32'd0);
        reset = 1'b0;
        idle(1);
        check("mid_rst_pass", pass_count, 32'd0);
        check("mid_rst_drop", drop_count, 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        beat(hit, FULL, 1'b1, 1'b1, 1'b0);
        idle(2);
        check("post_rst_first_beat", drop_count, 32'd1);
        // runt 20-byte first beat with matching header bytes -> forward
        beat(hit, 32'h000FFFFF, 1'b1, 1'b1, 1'b1);
        idle(2);
        check("runt_pass", pass_count, 32'd1);
        check("runt_drop", drop_count, 32'd1);
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
